mod_n_updown_counter: RTL
=========================

Name: mod_n_updown_counter

Overview:
Parametrised successor to the basic N-bit up counter. Counts up or down over a run-time programmable modulus, with synchronous clear, parallel load, count enable, and wrap or one-shot mode. It emits a registered terminal-count pulse and a halted status. It is the general timing/sequencing counter for workshop designs: timers, baud dividers, event counters.

Parameters:
WIDTH, 8, counter width in bits (2..32)
RST_VAL, 0, count_out value after reset and after clr
PRESCALE, 4, enable divide ratio (2..256); used only when COUNTER_PRESCALE_EN is defined

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  count enable; one step per enabled cycle
clr  input  1  synchronous clear to RST_VAL; also clears halted
load  input  1  synchronous parallel load of load_val; also clears halted
load_val  input  WIDTH  value loaded when load=1
dir  input  1  1 = up, 0 = down; sampled every enabled cycle
mode  input  1  0 = wrap (free-run), 1 = one-shot
mod_val  input  WIDTH  modulus; 0 means full range 2^WIDTH
count_out  output  WIDTH  registered count
done  output  1  registered one-cycle terminal-count pulse
halted  output  1  one-shot finished; counting frozen

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn). All other behaviour is synchronous to the rising edge of clk.
- Reset values: count_out=RST_VAL, done=0, halted=0. Reset mid-count aborts immediately.
- Priority each cycle: clr > load > en. Hold when none are active. done=0 in every cycle without a terminal step.
- Terminal value:
  - Up: T_up = mod_val-1, or 2^WIDTH-1 when mod_val=0.
  - Down: T_dn = 0.
- Up step:
  - If count_out >= T_up, this is a terminal step. The >= covers loaded or changed-modulus values above the range.
  - Otherwise count_out+1.
- Down step:
  - If count_out == 0, this is a terminal step.
  - Otherwise count_out-1.
  - If count_out > T_up, decrement normally.
- Terminal step, wrap mode:
  - Up: next count_out = 0.
  - Down: next count_out = T_up.
  - done=1 in the same cycle count_out shows the wrapped value, i.e. a one-cycle registered pulse.
- Terminal step, one-shot mode:
  - count_out holds at the terminal value (T_up or 0).
  - done=1 for one cycle; halted=1.
  - While halted, en is ignored. Only clr, load or rstn resume counting.
- Arithmetic is modulo 2^WIDTH internally. No intermediate value is ever exposed outside 0..2^WIDTH-1.
- clr or load in the same cycle as a would-be terminal step: clr/load wins, done=0.
- A dir, mode or mod_val change takes effect on the next enabled step. No pipeline; latency from en to count_out change is 1 cycle.
- mod_val=1: every enabled step is terminal. In wrap mode count_out stays 0 and done pulses every enabled cycle.
- Mode switch wrap→one-shot while not halted: no effect until the next terminal step. Switching one-shot→wrap while halted does not clear halted.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an internal prescaler counts en-high cycles; the counter steps only on every PRESCALE-th en-high cycle.
  - Prescaler resets to 0 on rstn, clr and load.
  - Prescaler holds while halted.
  - Latency from the PRESCALE-th en to the count change is 1 cycle.
- Undefined: no prescaler logic; every en-high cycle is a step. The PRESCALE parameter is ignored.

Decomposition:
- Package counter_pkg:
  - Enum cnt_dir_e {DIR_DOWN=0, DIR_UP=1}.
  - Enum cnt_mode_e {MODE_WRAP=0, MODE_ONESHOT=1}.
  - Function term_val(mod_val, width) returning T_up.
- Sub-module en_prescaler: parameter PRESCALE; ports clk, rstn, sync_clr, en_in, en_out. Instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- WIDTH=4, mod_val=10, dir=1, mode=0, en=1 from reset: count 0..9 then 0. done=1 only in the cycle count_out=0 after 9; repeats every 10 cycles.
- Same settings with dir=0, load_val=3 loaded: sequence 3,2,1,0,9,8. done pulses with count_out=9.
- mode=1, dir=1, mod_val=5: count 0..4 and holds at 4. done pulses once; halted=1; 10 further en cycles leave count_out=4. load of 2 → halted=0, counting resumes at 2.
- mod_val=0, WIDTH=4, up: count reaches 15 then wraps to 0 with done=1. Then load_val=12 with mod_val=8, up, en: next count_out=0, done=1.
- clr and load asserted together in a would-be terminal cycle: count_out=RST_VAL, done=0. Assert rstn low mid-count: count_out=RST_VAL, done=0, halted=0 asynchronously.
- With COUNTER_PRESCALE_EN, PRESCALE=4, en held high: count_out increments once per 4 cycles. clr mid-period restarts the 4-cycle phase.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the mod-N up/down counter.
// Holds the direction/mode encodings and the terminal-value helper.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} cnt_dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_ONESHOT = 1'b1} cnt_mode_e;

  // Up-count terminal value; a zero modulus selects the full 2^width range.
  function automatic logic [31:0] term_val(input logic [31:0] mod_val, input int unsigned width);
    logic [31:0] full;
    full = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (mod_val == 32'd0) ? full : (mod_val - 32'd1);
  endfunction

endpackage

// File: rtl/en_prescaler.sv
// Enable divider: passes through every PRESCALE-th en_in-high cycle.
// en_out is combinational so the counter steps on the same edge.
module en_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic sync_clr,
  input  logic en_in,
  output logic en_out
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign en_out = en_in && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en_in) begin
      cnt <= en_out ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Run-time modulus up/down counter with clear, load, wrap/one-shot and done pulse.
// Optional enable prescaler is built when COUNTER_PRESCALE_EN is defined.
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count_out,
  output logic             done,
  output logic             halted
);

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
    $error("mod_n_updown_counter: parameter out of range");
  end

  logic [WIDTH-1:0] t_up;
  logic             step;
  logic             is_up;
  logic             is_oneshot;
  logic             terminal;

  assign t_up       = WIDTH'(term_val(32'(mod_val), WIDTH));
  assign is_up      = (cnt_dir_e'(dir) == DIR_UP);
  assign is_oneshot = (cnt_mode_e'(mode) == MODE_ONESHOT);
  // >= catches counts left above the range by a load or a modulus change.
  assign terminal   = is_up ? (count_out >= t_up) : (count_out == '0);

`ifdef COUNTER_PRESCALE_EN
  en_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .rstn     (rstn),
    .sync_clr (clr | load),
    .en_in    (en & ~halted),
    .en_out   (step)
  );
`else
  assign step = en & ~halted;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_out <= RST_VAL;
      done      <= 1'b0;
      halted    <= 1'b0;
    end else if (clr) begin
      count_out <= RST_VAL;
      done      <= 1'b0;
      halted    <= 1'b0;
    end else if (load) begin
      count_out <= load_val;
      done      <= 1'b0;
      halted    <= 1'b0;
    end else if (step) begin
      done <= terminal;
      if (terminal) begin
        if (is_oneshot) begin
          count_out <= is_up ? t_up : '0;
          halted    <= 1'b1;
        end else begin
          count_out <= is_up ? '0 : t_up;
        end
      end else begin
        count_out <= is_up ? count_out + 1'b1 : count_out - 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule
